// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder built on one 4-bit ripple-carry adder
module RCA_four_bit (
    input  logic       cin,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic       cout,
    output logic [3:0] sum
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
        assign c[i + 1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d, sum_q, sum_d;
    logic [WIDTH-1:0] psum_shift;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       rca_sum;
    logic             rca_cout;
    logic             last;

    RCA_four_bit u_rca (
        .cin  (carry_q),
        .in1  (a_q[3:0]),
        .in2  (b_q[3:0]),
        .cout (rca_cout),
        .sum  (rca_sum)
    );

    // New nibble enters the partial sum from the MSB end; after NIBBLES shifts it is aligned.
    assign psum_shift = (psum_q >> 4) | (WIDTH'(rca_sum) << (WIDTH - 4));
    assign last       = cnt_q == CW'(NIBBLES - 1);

    // Next-state and datapath updates; ADD ignores start, IDLE and DONE both accept it.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (state_q == ADD) begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            psum_d  = psum_shift;
            carry_d = rca_cout;
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                sum_d   = psum_shift;
                cout_d  = rca_cout;
                state_d = DONE;
            end
        end else begin
            state_d = start ? ADD : IDLE;
            if (start) begin
                a_d     = in1;
                b_d     = in2;
                carry_d = cin;
                cnt_d   = '0;
            end
        end
    end

    // State and datapath registers; reset discards any in-flight addition.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = state_q == ADD;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the nibble-serial adder at WIDTH=4 and WIDTH=16
module tb_nibble_serial_adder;
    logic        clock = 0;
    logic        resetn = 0;
    logic        start4 = 0, cin4 = 0;
    logic [3:0]  a4 = 0, b4 = 0;
    logic        busy4, done4, cout4;
    logic [3:0]  sum4;
    logic        start = 0, cin = 0;
    logic [15:0] a = 0, b = 0;
    logic        busy, done, cout;
    logic [15:0] sum;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    nibble_serial_adder #(.WIDTH(4)) u4 (
        .clock(clock), .resetn(resetn), .start(start4), .in1(a4), .in2(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    nibble_serial_adder #(.WIDTH(16)) u16 (
        .clock(clock), .resetn(resetn), .start(start), .in1(a), .in2(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({busy, done, sum, cout} !== 19'd0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b sum=%h cout=%b, want all zero", busy, done, sum, cout);
        end
        checks++;
        if ({busy4, done4, sum4, cout4} !== 7'd0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b sum=%h cout=%b, want all zero", busy4, done4, sum4, cout4);
        end
        resetn = 1;
        step();
    endtask

    task automatic test_width4();
        a4 = 4'b1101; b4 = 4'b1000; cin4 = 1; start4 = 1;
        step();
        start4 = 0;
        checks++;
        if ({busy4, done4} !== 2'b10) begin
            errors++;
            $display("FAIL w4_busy: busy=%b done=%b, want 1 0", busy4, done4);
        end
        step();
        checks++;
        if ({busy4, done4, cout4, sum4} !== 7'b0_1_1_0110) begin
            errors++;
            $display("FAIL w4_done: busy=%b done=%b cout=%b sum=%b, want 0 1 1 0110", busy4, done4, cout4, sum4);
        end
        step();
        checks++;
        if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL w4_done_fall: done=%b, want 0", done4);
        end
    endtask

    task automatic test_carry_chain();
        int nbusy = 0;
        a = 16'hFFFF; b = 16'h0001; cin = 0; start = 1;
        step();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy) nbusy++;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL chain_early_done: cycle %0d done=%b, want 0", k, done);
            end
            step();
        end
        checks++;
        if ({busy, done, cout, sum} !== {3'b011, 16'h0000}) begin
            errors++;
            $display("FAIL chain_result: busy=%b done=%b cout=%b sum=%h, want 0 1 1 0000", busy, done, cout, sum);
        end
        checks++;
        if (nbusy !== 4) begin
            errors++;
            $display("FAIL chain_busy_cycles: got %0d, want 4", nbusy);
        end
        step();
    endtask

    task automatic test_operand_change();
        a = 16'h1234; b = 16'h4321; cin = 1; start = 1;
        step();
        start = 0; a = 16'hAAAA; b = 16'hAAAA; cin = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({busy, cout, sum} !== {2'b11, 16'h0000}) begin
                errors++;
                $display("FAIL opchg_hold: cycle %0d busy=%b cout=%b sum=%h, want 1 1 0000", k, busy, cout, sum);
            end
        end
        step();
        checks++;
        if ({done, cout, sum} !== {2'b10, 16'h5556}) begin
            errors++;
            $display("FAIL opchg_result: done=%b cout=%b sum=%h, want 1 0 5556", done, cout, sum);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        a = 16'h0001; b = 16'h0002; cin = 0; start = 1;
        step();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1;
        for (int k = 0; k < 4; k++) begin
            if (done) ndone++;
            step();
        end
        start = 0;
        checks++;
        if ({done, cout, sum} !== {2'b10, 16'h0003}) begin
            errors++;
            $display("FAIL ignore_result: done=%b cout=%b sum=%h, want 1 0 0003", done, cout, sum);
        end
        for (int k = 0; k < 10; k++) begin
            if (done) ndone++;
            step();
        end
        checks++;
        if (ndone !== 1 || sum !== 16'h0003) begin
            errors++;
            $display("FAIL ignore_pulses: done count=%0d sum=%h, want 1 0003", ndone, sum);
        end
    endtask

    task automatic test_back_to_back();
        a = 16'h8000; b = 16'h8000; cin = 0; start = 1;
        for (int k = 0; k < 15; k++) begin
            step();
            checks++;
            if (done !== (k % 5 == 4)) begin
                errors++;
                $display("FAIL b2b_done: step %0d done=%b, want %b", k, done, k % 5 == 4);
            end
            if (k % 5 == 4) begin
                checks++;
                if ({cout, sum} !== {1'b1, 16'h0000}) begin
                    errors++;
                    $display("FAIL b2b_result: step %0d cout=%b sum=%h, want 1 0000", k, cout, sum);
                end
            end
        end
        start = 0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        int ndone = 0;
        a = 16'h1111; b = 16'h2222; cin = 0; start = 1;
        step();
        start = 0;
        repeat (4) step();
        checks++;
        if ({done, cout, sum} !== {2'b10, 16'h3333}) begin
            errors++;
            $display("FAIL rst_pre: done=%b cout=%b sum=%h, want 1 0 3333", done, cout, sum);
        end
        step();
        a = 16'h0101; b = 16'h0101; start = 1;
        step();
        start = 0;
        step();
        #3 resetn = 0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== 19'd0) begin
            errors++;
            $display("FAIL rst_async: busy=%b done=%b cout=%b sum=%h, want all zero", busy, done, cout, sum);
        end
        #10 resetn = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL rst_no_done: saw %0d busy/done cycles after release, want 0", ndone);
        end
        a = 16'h0F0F; b = 16'h00F1; cin = 0; start = 1;
        step();
        start = 0;
        repeat (4) step();
        checks++;
        if ({done, cout, sum} !== {2'b10, 16'h1000}) begin
            errors++;
            $display("FAIL rst_after: done=%b cout=%b sum=%h, want 1 0 1000", done, cout, sum);
        end
    endtask

    initial begin
        test_reset();
        test_width4();
        test_carry_chain();
        test_operand_change();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around one internal RCA_four_bit instance (cin, in1, in2, cout, sum port order).
- Processes one 4-bit nibble per clock and registers the inter-nibble carry.
- Sits directly downstream of the 4-bit ripple-carry adder: it consumes the adder's sum/cout each cycle and assembles the wide result.
- Provides a start/busy/done handshake to the controlling logic.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4: derived. Number of ADD cycles; not to be overridden.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request an addition; sampled on rising clock edge
- in1  input  WIDTH  operand A; sampled only when start is accepted
- in2  input  WIDTH  operand B; sampled only when start is accepted
- cin  input  1  carry-in to nibble 0; sampled only when start is accepted
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout are updated
- sum  output  WIDTH  registered result of the last completed addition
- cout  output  1  registered carry-out of the last completed addition

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, partial-sum register, carry register and nibble counter cleared.
  - Takes effect immediately, including mid-operation; the in-flight addition is discarded and no done is generated.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at an edge accepts the request: load in1/in2 into operand shift registers, carry_reg<=cin, count<=0, go to ADD.
  - start=0: stay in IDLE.
- ADD (busy=1):
  - Each cycle the RCA adds the low nibbles of both operand registers plus carry_reg.
  - At the edge: RCA sum nibble is shifted into the partial-sum register from the MSB end; operand registers shift right by 4; carry_reg<=RCA cout; count increments.
  - When count==NIBBLES-1 at the edge: sum<=final assembled value, cout<=final RCA cout, go to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - start=1 accepts a new request exactly as from IDLE and goes to ADD (back-to-back operation).
  - start=0: go to IDLE.
- start while in ADD is ignored. Operands are not re-sampled and no queueing occurs.
- Latency: start accepted at edge E0; sum/cout update and done rises at edge E(NIBBLES); done falls at E(NIBBLES+1). Throughput is one result per NIBBLES+1 cycles.
- sum/cout hold the previous result throughout ADD and change only on the completing edge. They hold until the next completion or reset.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of in1+in2+cin. Input changes after acceptance have no effect on the result.
- WIDTH=4 edge case: a single ADD cycle; behaviour is otherwise identical.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=4; in1=4'b1101, in2=4'b1000, cin=1; start pulsed one cycle -> busy for 1 cycle; done high 1 cycle after acceptance; sum=4'b0110, cout=1.
- WIDTH=16; in1=16'hFFFF, in2=16'h0001, cin=0 -> done exactly 4 edges after start; sum=16'h0000, cout=1; busy high exactly 4 cycles.
- WIDTH=16; in1=16'h1234, in2=16'h4321, cin=1 -> sum=16'h5556, cout=0. Operands changed to 16'hAAAA during busy -> result unchanged; sum keeps its prior value until done.
- WIDTH=16; start re-asserted during ADD with different operands -> ignored; only the first result appears; exactly one done pulse.
- WIDTH=16; start held high continuously with in1=16'h8000, in2=16'h8000, cin=0 -> done every 5 cycles; each result sum=16'h0000, cout=1; no lost or duplicate done.
- WIDTH=16; resetn pulled low asynchronously (mid-cycle) at cycle 2 of ADD -> busy, done, sum, cout go to 0 immediately; no done after release; a subsequent start of 16'h0F0F+16'h00F1, cin=0 gives sum=16'h1000, cout=0.
